// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM states, branch
// encoding and the jump-target table that the assembler tables also use.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      PRIME  = 3'd2,
      RUN    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [2:0] BR_OPCODE = 3'b111;

   typedef enum logic [1:0] {
      CC_ALWAYS = 2'b00,
      CC_ZERO   = 2'b01,
      CC_NEG    = 2'b10,
      CC_NZERO  = 2'b11
   } cond_t;

   localparam logic [7:0] JUMP_LUT [16] = '{
      8'd5,   8'd17,  8'd29,  8'd40,  8'd52,  8'd63,  8'd77,  8'd90,
      8'd101, 8'd118, 8'd130, 8'd147, 8'd166, 8'd181, 8'd200, 8'd233
   };

   function automatic logic cond_met(input cond_t cc, input logic z, input logic n);
      logic met;
      met = 1'b0;
      case (cc)
         CC_ALWAYS: met = 1'b1;
         CC_ZERO:   met = z;
         CC_NEG:    met = n;
         CC_NZERO:  met = ~z;
         default:   met = 1'b0;
      endcase
      return met;
   endfunction

endpackage

// File: rtl/run_ctrl_jump_lut.sv
// Combinational branch-target lookup: 4-bit index into the shared
// 16-entry jump table.
module jump_lut
   import run_ctrl_pkg::*;
(
   input  logic [3:0] idx,
   output logic [7:0] target
);

   assign target = JUMP_LUT[idx];

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer and branch resolver for the program counter / ROM pair.
// Optional retired-cycle counter built only with RUN_CTRL_CYCLE_COUNT_EN.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int WDOG_MAX = 1023,
   parameter int CYC_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Req,
   input  logic [1:0]       Problem_in,
   output logic             Ack,
   output logic             Timeout,
   output logic             start,
   output logic [1:0]       problem,
   input  logic [7:0]       PC,
   input  logic [8:0]       Instruction,
   input  logic             pc_done_flag,
   input  logic             Zero_in,
   input  logic             Neg_in,
   input  logic             Flag_we,
   output logic             Jen,
   output logic [7:0]       Jump,
   output logic [7:0]       PC_prev,
   output logic [CYC_W-1:0] Cycles,
   output state_t           state_dbg
);

   localparam int WD_W = ($clog2(WDOG_MAX + 1) > 10) ? $clog2(WDOG_MAX + 1) : 10;

   state_t          state, state_next;
   logic [1:0]      problem_r;
   logic            z_r, n_r;
   logic [WD_W-1:0] wdog;
   logic            timeout_r;
   logic            wdog_hit;
   logic            taken;
   logic [7:0]      lut_target;

   jump_lut u_jump_lut (
      .idx    (Instruction[3:0]),
      .target (lut_target)
   );

   assign wdog_hit = (wdog == WD_W'(WDOG_MAX - 1));
   assign taken    = (Instruction[8:6] == BR_OPCODE) &&
                     cond_met(cond_t'(Instruction[5:4]), z_r, n_r);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Req/Ack is a four-phase level handshake: Req rises and is held until
   // Ack rises; Ack is held until Req falls; Req falling mid-run is ignored.
   always_comb begin
      state_next = state;
      Jen        = 1'b0;
      Jump       = 8'h00;
      PC_prev    = PC;
      case (state)
         IDLE: begin
            Jen  = 1'b1;
            Jump = PC;
            if (Req) state_next = LAUNCH;
         end
         LAUNCH: state_next = PRIME;
         PRIME:  state_next = RUN;
         RUN: begin
            if (taken) begin
               Jen  = 1'b1;
               Jump = lut_target;
            end
            if (pc_done_flag || wdog_hit) state_next = DONE;
         end
         DONE: begin
            Jen  = 1'b1;
            Jump = PC;
            if (!Req) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Reset forces the PC-facing outputs low immediately, not at the next edge.
      if (!Reset_n) begin
         Jen     = 1'b0;
         Jump    = 8'h00;
         PC_prev = 8'h00;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         problem_r <= 2'b00;
         z_r       <= 1'b0;
         n_r       <= 1'b0;
         wdog      <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (state == IDLE && Req) problem_r <= Problem_in;
         if (state == LAUNCH) begin
            z_r       <= 1'b0;
            n_r       <= 1'b0;
            wdog      <= '0;
            timeout_r <= 1'b0;
         end else if (state == RUN) begin
            if (Flag_we) begin
               z_r <= Zero_in;
               n_r <= Neg_in;
            end
            wdog <= wdog + 1'b1;
            // A coincident done flag takes priority over the watchdog.
            if (wdog_hit && !pc_done_flag) timeout_r <= 1'b1;
         end
      end
   end

`ifdef RUN_CTRL_CYCLE_COUNT_EN
   logic [CYC_W-1:0] cyc;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                     cyc <= '0;
      else if (state == LAUNCH)         cyc <= '0;
      else if (state == RUN && ~&cyc)   cyc <= cyc + 1'b1;
   end

   assign Cycles = cyc;
`else
   assign Cycles = '0;
`endif

   assign start     = (state == LAUNCH);
   assign Ack       = (state == DONE);
   assign Timeout   = timeout_r && (state == DONE);
   assign problem   = problem_r;
   assign state_dbg = state;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed handshake/branch/watchdog/reset
// scenarios plus randomized runs against a run-level reference model.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   localparam int WDOG  = 8;
   localparam int CYC_W = 16;

   logic             Clk = 1'b0;
   logic             Reset_n = 1'b0;
   logic             Req = 1'b0;
   logic [1:0]       Problem_in = 2'b00;
   logic             Ack, Timeout, start;
   logic [1:0]       problem;
   logic [7:0]       PC = 8'h33;
   logic [8:0]       Instruction = 9'h000;
   logic             pc_done_flag = 1'b0;
   logic             Zero_in = 1'b0, Neg_in = 1'b0, Flag_we = 1'b0;
   logic             Jen;
   logic [7:0]       Jump, PC_prev;
   logic [CYC_W-1:0] Cycles;
   state_t           state_dbg;

   // Independent copy of the assembler jump table.
   logic [7:0] tb_lut [16] = '{
      8'd5,   8'd17,  8'd29,  8'd40,  8'd52,  8'd63,  8'd77,  8'd90,
      8'd101, 8'd118, 8'd130, 8'd147, 8'd166, 8'd181, 8'd200, 8'd233
   };

   int          n_cmp = 0;
   int          n_err = 0;
   logic [16:0] exp_q[$];
   bit          mz, mn, exp_to;
   int          run_cnt = 0;

   always #5 Clk = ~Clk;

   run_ctrl #(.WDOG_MAX(WDOG), .CYC_W(CYC_W)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Req          (Req),
      .Problem_in   (Problem_in),
      .Ack          (Ack),
      .Timeout      (Timeout),
      .start        (start),
      .problem      (problem),
      .PC           (PC),
      .Instruction  (Instruction),
      .pc_done_flag (pc_done_flag),
      .Zero_in      (Zero_in),
      .Neg_in       (Neg_in),
      .Flag_we      (Flag_we),
      .Jen          (Jen),
      .Jump         (Jump),
      .PC_prev      (PC_prev),
      .Cycles       (Cycles),
      .state_dbg    (state_dbg)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_cycles(input int cnt);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
      return 32'(cnt);
`else
      return 32'(cnt * 0);
`endif
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Entered in IDLE just after a rising edge; leaves in the first RUN cycle.
   task automatic start_run(input logic [1:0] prob);
      PC = 8'($urandom_range(0, 255));
      Req = 1'b1;
      Problem_in = prob;
      @(negedge Clk);
      check_eq("idle_jen", Jen, 1);
      check_eq("idle_jump", Jump, PC);
      check_eq("idle_ack", Ack, 0);
      check_eq("idle_start", start, 0);
      tick();
      @(negedge Clk);
      check_eq("launch_start", start, 1);
      check_eq("launch_jen", Jen, 0);
      PC = 8'hFF;
      tick();
      @(negedge Clk);
      check_eq("prime_start", start, 0);
      check_eq("prime_problem", problem, prob);
      check_eq("prime_jen", Jen, 0);
      check_eq("prime_pc_prev", PC_prev, 8'hFF);
      mz = 1'b0;
      mn = 1'b0;
      run_cnt = 0;
      exp_q.delete();
      tick();
   endtask

   task automatic run_cycle(input logic [8:0] instr, input logic [7:0] pc, input bit we,
                            input bit zi, input bit ni, input bit done, output bit ended);
      bit          taken;
      logic [1:0]  cc;
      logic [16:0] e;
      Instruction = instr;
      PC = pc;
      Flag_we = we;
      Zero_in = zi;
      Neg_in = ni;
      pc_done_flag = done;
      run_cnt++;
      cc = instr[5:4];
      taken = (instr[8:6] == 3'b111) &&
              (cc == 2'd0 || (cc == 2'd1 && mz) || (cc == 2'd2 && mn) || (cc == 2'd3 && !mz));
      exp_q.push_back({taken, taken ? tb_lut[instr[3:0]] : 8'h00, pc});
      @(negedge Clk);
      e = exp_q.pop_front();
      check_eq("run_jen", Jen, e[16]);
      check_eq("run_jump", Jump, e[15:8]);
      check_eq("run_pc_prev", PC_prev, e[7:0]);
      check_eq("run_ack", Ack, 0);
      if (we) begin
         mz = zi;
         mn = ni;
      end
      ended = done || (run_cnt == WDOG);
      exp_to = !done && (run_cnt == WDOG);
      tick();
      pc_done_flag = 1'b0;
      Flag_we = 1'b0;
   endtask

   task automatic finish_run(input int hold);
      PC = 8'($urandom_range(0, 255));
      @(negedge Clk);
      check_eq("done_ack", Ack, 1);
      check_eq("done_timeout", Timeout, exp_to);
      check_eq("done_jen", Jen, 1);
      check_eq("done_jump", Jump, PC);
      check_eq("done_cycles", Cycles, exp_cycles(run_cnt));
      if (Req) begin
         for (int i = 0; i < hold; i++) begin
            tick();
            @(negedge Clk);
            check_eq("hold_ack", Ack, 1);
         end
      end
      Req = 1'b0;
      tick();
      @(negedge Clk);
      check_eq("release_ack", Ack, 0);
      check_eq("release_timeout", Timeout, 0);
      check_eq("release_jump", Jump, PC);
      check_eq("release_cycles", Cycles, exp_cycles(run_cnt));
      tick();
   endtask

   task automatic random_run(input int done_at, input int drop_at);
      bit         ended;
      logic [8:0] ins;
      int         k;
      start_run(2'($urandom_range(0, 3)));
      k = 0;
      ended = 1'b0;
      while (!ended) begin
         k++;
         ins = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 1) == 1) ins[8:6] = 3'b111;
         if (k == drop_at) Req = 1'b0;
         run_cycle(ins, (k == 1) ? 8'h00 : 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), k == done_at, ended);
      end
      finish_run(int'($urandom_range(0, 2)));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      bit ended;
      #3;
      check_eq("rst_ack", Ack, 0);
      check_eq("rst_timeout", Timeout, 0);
      check_eq("rst_start", start, 0);
      check_eq("rst_problem", problem, 0);
      check_eq("rst_jen", Jen, 0);
      check_eq("rst_jump", Jump, 0);
      check_eq("rst_pc_prev", PC_prev, 0);
      check_eq("rst_cycles", Cycles, 0);
      check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
      #10 Reset_n = 1'b1;
      tick();

      // Unconditional and flag-conditional branches, including same-cycle flag write.
      start_run(2'b01);
      run_cycle(9'b111_00_0011, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ended);
      run_cycle(9'b000_00_0000, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, ended);
      run_cycle(9'b111_01_0011, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, ended);
      run_cycle(9'b111_01_0011, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, ended);
      run_cycle(9'b111_10_0101, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, ended);
      run_cycle(9'b111_10_0101, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, ended);
      run_cycle(9'b111_11_0111, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, ended);
      finish_run(1);

      // Watchdog on a self-loop, then done coinciding with expiry.
      start_run(2'b10);
      ended = 1'b0;
      while (!ended) run_cycle(9'b111_00_0011, 8'd40, 1'b0, 1'b0, 1'b0, 1'b0, ended);
      finish_run(0);
      random_run(WDOG, 0);

      // Asynchronous reset mid-run.
      start_run(2'b11);
      for (int i = 0; i < 3; i++)
         run_cycle(9'b111_00_0001, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, ended);
      #2;
      PC = 8'h5A;
      Reset_n = 1'b0;
      #1;
      check_eq("arst_ack", Ack, 0);
      check_eq("arst_start", start, 0);
      check_eq("arst_problem", problem, 0);
      check_eq("arst_jen", Jen, 0);
      check_eq("arst_jump", Jump, 0);
      check_eq("arst_pc_prev", PC_prev, 0);
      check_eq("arst_cycles", Cycles, 0);
      check_eq("arst_state", 32'(state_dbg), 32'(IDLE));
      Req = 1'b0;
      #2 Reset_n = 1'b1;
      tick();
      tick();
      @(negedge Clk);
      check_eq("post_rst_state", 32'(state_dbg), 32'(IDLE));
      check_eq("post_rst_ack", Ack, 0);
      check_eq("post_rst_jump", Jump, PC);
      tick();

      repeat (30) random_run(int'($urandom_range(1, WDOG + 3)), int'($urandom_range(0, WDOG + 3)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
